// File: rtl/relu_result_writeback_pkg.sv
// relu_result_writeback_pkg: shared state type, default lane sizing and address-width helper
package relu_result_writeback_pkg;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_NUM_UNITS = 2;
    typedef logic [DEF_NUM_UNITS-1:0] lane_vec_t;
    typedef enum logic [1:0] {IDLE, LOAD, EMIT} wb_state_t;
    function automatic int addr_w(input int w, input int h);
        return (w * h > 1) ? $clog2(w * h) : 1;
    endfunction
endpackage

// File: rtl/relu_result_writeback_if.sv
// relu_result_writeback_if: valid/ready result stream carrying one element plus its image address
interface relu_result_writeback_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W = 6
);
    logic valid;
    logic ready;
    logic last;
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_W-1:0] addr;
    modport master(output valid, data, addr, last, input ready);
    modport slave(input valid, data, addr, last, output ready);
endinterface

// File: rtl/relu_result_writeback_fifo.sv
// result_fifo: synchronous FIFO of capture entries; a push at full is accepted when a pop happens in the same cycle
module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full = level == (PTR_W+1)'(DEPTH);
    assign empty = level == '0;
    assign rdata = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + PTR_W'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
            level <= level + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end
endmodule

// File: rtl/relu_result_writeback.sv
// relu_result_writeback: captures ReLU lane results, buffers them and streams one addressed element per cycle
// Define TPU_WB_CLAMP_EN to saturate emitted elements at CLAMP_MAX.
module relu_result_writeback
    import relu_result_writeback_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_UNITS = 2,
    parameter int IMAGE_WIDTH = 8,
    parameter int IMAGE_HEIGHT = 8,
    parameter int FIFO_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] CLAMP_MAX = 'h00FF,
    localparam int ADDR_W = addr_w(IMAGE_WIDTH, IMAGE_HEIGHT),
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          done_in,
    input  logic [NUM_UNITS-1:0]          active_units,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] relu_in,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic                          addr_load,
    relu_result_writeback_if.master       out_if,
    output logic [LVL_W-1:0]              fifo_level,
    output logic                          overflow,
    output logic                          busy
);
    localparam int ENTRY_W = NUM_UNITS * DATA_WIDTH + NUM_UNITS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);
    wb_state_t state;
    logic [NUM_UNITS*DATA_WIDTH-1:0] lanes, head_data;
    logic [NUM_UNITS-1:0] mask, low, rest, head_mask;
    logic [ENTRY_W-1:0] head;
    logic [ADDR_W-1:0] addr;
    logic [DATA_WIDTH-1:0] lane;
    logic cap, pop, full, empty, hs, drop, reload, addr_ok, last;
    assign cap = done_in && |active_units;
    assign hs = out_if.valid && out_if.ready;
    assign low = mask & (~mask + NUM_UNITS'(1));
    assign rest = mask & ~low;
    // refill straight from the FIFO on the final handshake so back-to-back captures stream without a gap
    assign reload = hs && rest == '0 && !empty;
    assign pop = (state == LOAD) || reload;
    assign drop = cap && full && !pop;
    assign busy = !empty || state != IDLE;
    assign addr_ok = addr_load && !busy;
    assign last = addr == LAST_ADDR;
    assign {head_data, head_mask} = head;
    result_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(cap),
        .pop(pop),
        .wdata({relu_in, active_units}),
        .rdata(head),
        .full(full),
        .empty(empty),
        .level(fifo_level)
    );
    always_comb begin
        lane = '0;
        for (int i = 0; i < NUM_UNITS; i++) lane |= low[i] ? lanes[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
    assign out_if.valid = state == EMIT;
    assign out_if.addr = addr;
    assign out_if.last = last;
`ifdef TPU_WB_CLAMP_EN
    assign out_if.data = lane > CLAMP_MAX ? CLAMP_MAX : lane;
`else
    logic unused_clamp;
    assign unused_clamp = ^CLAMP_MAX;
    assign out_if.data = lane;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            lanes <= '0;
            mask <= '0;
            addr <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= drop ? 1'b1 : addr_ok ? 1'b0 : overflow;
            addr <= hs ? (last ? '0 : addr + ADDR_W'(1)) : addr_ok ? base_addr : addr;
            if (pop) begin
                lanes <= head_data;
                mask <= head_mask;
            end else if (hs) begin
                mask <= rest;
            end
            case (state)
                IDLE: state <= (cap || !empty) ? LOAD : IDLE;
                LOAD: state <= EMIT;
                EMIT: state <= (!hs || rest != '0 || reload) ? EMIT : cap ? LOAD : IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
